// File: rtl/aes_inv_round_ctrl.sv
// AES-128 inverse cipher round sequencer.
// Accepts a ciphertext and round-NR key, applies the initial AddRoundKey, then
// drives the shared full-round datapath for NR-1 cycles and the final-round
// datapath for one cycle. It presents the plaintext until the consumer takes it.
// Optional build macro AES_INV_CTRL_ABORT_EN adds an 'abort' input. When abort
// is high in any busy state, the job is dropped and the controller returns to IDLE.
module aes_inv_round_ctrl #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] ct_in,
    input  logic [W-1:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] pt_out,
    output logic [3:0]   rnd_rc,
    output logic [W-1:0] rnd_data,
    output logic [W-1:0] rnd_key,
    input  logic [W-1:0] rnd_out,
    input  logic [W-1:0] rnd_keyout,
    input  logic [W-1:0] fin_out
`ifdef AES_INV_CTRL_ABORT_EN
    ,
    input  logic         abort
`endif
);

    // rc is 4 bits wide and must never wrap.
    if (NR < 1 || NR > 15) begin : g_bad_nr
        $error("aes_inv_round_ctrl: NR must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Last round count that still uses the full-round datapath.
    localparam logic [3:0] RC_LAST_FULL = 4'(NR - 1);
    // With a single round, the accepted block goes straight to the final round.
    localparam state_t     FIRST_STATE  = (NR == 1) ? FINAL : ROUND;

    state_t       state;
    state_t       state_nxt;
    logic [W-1:0] state_reg;
    logic [W-1:0] state_nxt_val;
    logic [W-1:0] key_reg;
    logic [W-1:0] key_nxt_val;
    logic [3:0]   rc;
    logic [3:0]   rc_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign pt_out    = state_reg;
    assign rnd_data  = state_reg;
    assign rnd_key   = key_reg;
    assign rnd_rc    = rc;

    // Next-state and next-register values. The datapath inputs are only
    // selected in ROUND and FINAL, so garbage on them elsewhere is never captured.
    always_comb begin
        state_nxt     = state;
        state_nxt_val = state_reg;
        key_nxt_val   = key_reg;
        rc_nxt        = rc;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt_val = ct_in ^ key_in;
                    key_nxt_val   = key_in;
                    rc_nxt        = 4'd1;
                    state_nxt     = FIRST_STATE;
                end
            end
            ROUND: begin
                state_nxt_val = rnd_out;
                key_nxt_val   = rnd_keyout;
                rc_nxt        = rc + 4'd1;
                if (rc == RC_LAST_FULL) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                state_nxt_val = fin_out;
                key_nxt_val   = rnd_keyout;
                state_nxt     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                    rc_nxt    = 4'd0;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef AES_INV_CTRL_ABORT_EN
        // Abort overrides everything, including a plaintext handshake in DONE.
        if (abort && (state != IDLE)) begin
            state_nxt     = IDLE;
            state_nxt_val = '0;
            key_nxt_val   = '0;
            rc_nxt        = 4'd0;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Cipher state, round key and round counter feedback registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= '0;
            key_reg   <= '0;
            rc        <= 4'd0;
        end else begin
            state_reg <= state_nxt_val;
            key_reg   <= key_nxt_val;
            rc        <= rc_nxt;
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Testbench for aes_inv_round_ctrl.
// It provides reference AES inverse-round datapaths and an edge-counting job
// model. The model predicts the handshake, round counter and plaintext every
// cycle. The stimulus is randomised.
module tb_aes_inv_round_ctrl;

    localparam int NR = 10;
    localparam int W  = 128;

    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ct_in;
    logic [W-1:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] pt_out;
    logic [3:0]   rnd_rc;
    logic [W-1:0] rnd_data;
    logic [W-1:0] rnd_key;
    logic [W-1:0] rnd_out;
    logic [W-1:0] rnd_keyout;
    logic [W-1:0] fin_out;
    logic         abort;

    int n_checks = 0;
    int n_fail   = 0;

    aes_inv_round_ctrl #(.NR(NR), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ct_in      (ct_in),
        .key_in     (key_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pt_out     (pt_out),
        .rnd_rc     (rnd_rc),
        .rnd_data   (rnd_data),
        .rnd_key    (rnd_key),
        .rnd_out    (rnd_out),
        .rnd_keyout (rnd_keyout),
        .fin_out    (fin_out)
`ifdef AES_INV_CTRL_ABORT_EN
        ,
        .abort      (abort)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- AES arithmetic ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        int e;
        r = 8'h01;
        base = a;
        e = 254;
        while (e != 0) begin
            if (e % 2 == 1) r = gmul(r, base);
            base = gmul(base, base);
            e = e / 2;
        end
        return (a == 8'h00) ? 8'h00 : r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} >> (8 - n);
        return d[7:0];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] y);
        return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] get_b(input logic [127:0] s, input int n);
        return s[127 - 8*n -: 8];
    endfunction

    // InvShiftRows followed by InvSubBytes; byte index n = row + 4*column.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127 - 8*(r + 4*c) -: 8] = inv_sbox(get_b(s, r + 4*((c - r + 4) % 4)));
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = get_b(s, 4*c);
            a1 = get_b(s, 4*c + 1);
            a2 = get_b(s, 4*c + 2);
            a3 = get_b(s, 4*c + 3);
            o[127 - 8*(4*c)     -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
            o[127 - 8*(4*c + 1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
            o[127 - 8*(4*c + 2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
            o[127 - 8*(4*c + 3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [7:0] rcon(input int i);
        logic [7:0] r;
        r = 8'h01;
        for (int j = 1; j < i; j++) r = xtime(r);
        return r;
    endfunction

    // Round key i -> round key i-1, where i = NR+1-rc.
    function automatic logic [127:0] inv_key_step(input logic [127:0] k, input int rc);
        logic [31:0] w0, w1, w2, w3, t, sw;
        if (rc < 1 || rc > NR) return k;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        t  = {w3[23:0], w3[31:24]};
        sw = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        w0 = w0 ^ sw ^ {rcon(NR + 1 - rc), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] full_round(input logic [127:0] s, input logic [127:0] k);
        return inv_mix(inv_shift_sub(s) ^ k);
    endfunction

    function automatic logic [127:0] final_round(input logic [127:0] s, input logic [127:0] k);
        return inv_shift_sub(s) ^ k;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [127:0] s;
        logic [127:0] k;
        s = ct ^ key;
        k = key;
        for (int rc = 1; rc <= NR; rc++) begin
            k = inv_key_step(k, rc);
            s = (rc < NR) ? full_round(s, k) : final_round(s, k);
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference round datapaths driven from the controller's outputs.
    always_comb begin
        rnd_keyout = inv_key_step(rnd_key, int'(rnd_rc));
        rnd_out    = full_round(rnd_data, rnd_keyout);
        fin_out    = final_round(rnd_data, rnd_keyout);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- Job model: counts edges since the accepting edge ----------------
    bit           m_busy = 1'b0;
    int           m_n    = 0;
    int           m_done = 0;
    bit [127:0]   m_exp  = '0;
    bit [127:0]   m_last = '0;
    bit [127:0]   m_first = '0;
    bit [127:0]   m_key0 = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_n    <= 0;
            m_last <= '0;
        end
`ifdef AES_INV_CTRL_ABORT_EN
        else if (abort && m_busy) begin
            m_busy <= 1'b0;
            m_n    <= 0;
            m_last <= '0;
        end
`endif
        else if (m_busy && m_n == NR + 1) begin
            if (out_ready) begin
                m_busy <= 1'b0;
                m_last <= m_exp;
                m_done <= m_done + 1;
            end
        end else if (m_busy) begin
            m_n <= m_n + 1;
        end else if (in_valid) begin
            m_busy  <= 1'b1;
            m_n     <= 1;
            m_exp   <= aes_dec(ct_in, key_in);
            m_first <= ct_in ^ key_in;
            m_key0  <= key_in;
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        int e_rc;
        e_rc = !m_busy ? 0 : ((m_n > NR) ? NR : m_n);
        check("in_ready", in_ready, !m_busy);
        check("out_valid", out_valid, m_busy && (m_n == NR + 1));
        check("rnd_rc", rnd_rc, e_rc);
        if (!m_busy) check("pt_idle", pt_out, m_last);
        else if (m_n == NR + 1) check("pt_done", pt_out, m_exp);
        if (m_busy && m_n == 1) begin
            check("rnd_data_first", rnd_data, m_first);
            check("rnd_key_first", rnd_key, m_key0);
        end
    end

    // ---------------- Directed helpers ----------------
    task automatic accept(input logic [127:0] ct, input logic [127:0] key);
        int g;
        g = 0;
        while (!in_ready && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        ct_in    = ct;
        key_in   = key;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [127:0] ct, input logic [127:0] key, input bit scramble,
                           output logic [127:0] pt, output int lat);
        accept(ct, key);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (scramble) begin
                ct_in    = rand128();
                key_in   = rand128();
                in_valid = 1'($urandom % 2);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        pt = pt_out;
    endtask

    task automatic wait_rc(input int v);
        int g;
        g = 0;
        while (rnd_rc != 4'(v) && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        check("wait_rc", rnd_rc, v);
    endtask

    initial begin
        logic [127:0] pt;
        logic [127:0] ct_a, key_a, ct_b, key_b;
        int lat;
        int g;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        ct_in = '0; key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_pt_out", pt_out, 128'h0);
        check("reset_rc", rnd_rc, 4'd0);
        rst_n = 1'b1;

        // Pin the reference arithmetic with known values.
        check("sbox_00", sbox(8'h00), 8'h63);
        check("sbox_53", sbox(8'h53), 8'hed);
        check("inv_sbox_ed", inv_sbox(8'hed), 8'h53);
        check("model_c1", aes_dec(C1_CT, C1_KEY), C1_PT);

        // C.1 vector with inputs scrambled every cycle after accept.
        out_ready = 1'b1;
        run_job(C1_CT, C1_KEY, 1'b1, pt, lat);
        check("c1_latency", lat, NR + 1);
        check("c1_pt", pt, C1_PT);
        @(posedge clk); #1;

        // Backpressure, followed by a back-to-back second vector held on in_valid.
        out_ready = 1'b0;
        ct_a = rand128(); key_a = rand128();
        ct_b = rand128(); key_b = rand128();
        run_job(ct_a, key_a, 1'b0, pt, lat);
        check("bp_latency", lat, NR + 1);
        check("bp_pt_a", pt, aes_dec(ct_a, key_a));
        in_valid = 1'b1; ct_in = ct_b; key_in = key_b;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_pt_stable", pt_out, aes_dec(ct_a, key_a));
            check("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        check("b2b_accepted", in_ready, 1'b0);
        check("b2b_rc", rnd_rc, 4'd1);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        check("b2b_pt_b", pt_out, aes_dec(ct_b, key_b));
        @(posedge clk); #1;

        // Randomised traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 800; c++) begin
            in_valid  = 1'($urandom % 2);
            ct_in     = rand128();
            key_in    = rand128();
            out_ready = ($urandom % 3) != 0;
`ifdef AES_INV_CTRL_ABORT_EN
            abort     = ($urandom % 20) == 0;
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; abort = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("random_jobs_done", m_done > 0, 1'b1);

        // Asynchronous reset in the middle of a job.
        accept(rand128(), rand128());
        wait_rc(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_pt_out", pt_out, 128'h0);
        check("arst_rc", rnd_rc, 4'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        ct_a = rand128(); key_a = rand128();
        run_job(ct_a, key_a, 1'b0, pt, lat);
        check("arst_after_latency", lat, NR + 1);
        check("arst_after_pt", pt, aes_dec(ct_a, key_a));
        @(posedge clk); #1;

`ifdef AES_INV_CTRL_ABORT_EN
        // Abort mid-job.
        accept(rand128(), rand128());
        wait_rc(4);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_state_reg", pt_out, 128'h0);
        check("abort_rc", rnd_rc, 4'd0);
        repeat (14) @(posedge clk);
        #1;

        // Abort in DONE wins over out_ready.
        out_ready = 1'b0;
        run_job(rand128(), rand128(), 1'b0, pt, lat);
        check("abort_done_valid", out_valid, 1'b1);
        abort = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_done_ready", in_ready, 1'b1);
        check("abort_done_pt", pt_out, 128'h0);

        // Abort in IDLE is ignored; the block is still accepted.
        ct_a = rand128(); key_a = rand128();
        in_valid = 1'b1; abort = 1'b1; ct_in = ct_a; key_in = key_a;
        @(posedge clk); #1;
        in_valid = 1'b0; abort = 1'b0;
        check("abort_idle_accepted", in_ready, 1'b0);
        g = 0;
        while (!out_valid && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        check("abort_idle_pt", pt_out, aes_dec(ct_a, key_a));
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
